// File: rtl/ipsxe_floating_point_axis_fifo_ctrl_v1_0_if.sv
// AXI-stream channel bundle used on both the input and output side of the FIFO controller.
// The master drives tdata/tvalid and the slave drives tready.
interface ipsxe_floating_point_axis_fifo_ctrl_v1_0_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv
// Write/read controller pairing with a dual-port SRAM to form an AXI-stream FWFT FIFO.
// The registered output stage is fed from the SRAM read port, or directly from the input when the SRAM is empty.
module ipsxe_floating_point_axis_fifo_ctrl_v1_0 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                                          i_aclk,
    input  logic                                          i_rst,
    ipsxe_floating_point_axis_fifo_ctrl_v1_0_if.slave     s_axis,
    ipsxe_floating_point_axis_fifo_ctrl_v1_0_if.master    m_axis,
    output logic [DATA_WIDTH-1:0]                         o_mem_d,
    output logic [ADDR_WIDTH-1:0]                         o_mem_wa,
    output logic                                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]                         o_mem_ra,
    output logic                                          o_mem_re,
    input  logic [DATA_WIDTH-1:0]                         i_mem_q,
    output logic [ADDR_WIDTH:0]                           o_count
);
    localparam int                    CNT_W    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] ptr);
        logic [ADDR_WIDTH-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {ADDR_WIDTH{1'b0}};
        end else begin
            nxt = ptr + ADDR_WIDTH'(1);
        end
        return nxt;
    endfunction

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      mem_cnt_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_valid_r;

    logic ready_s;
    logic push_s;
    logic out_free_s;
    logic load_s;
    logic bypass_s;
    logic write_s;

    // Handshake qualification: decide load, bypass or SRAM write for this cycle.
    always_comb begin
        ready_s    = 1'b0;
        push_s     = 1'b0;
        out_free_s = 1'b0;
        load_s     = 1'b0;
        bypass_s   = 1'b0;
        write_s    = 1'b0;
        if (i_rst) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (mem_cnt_r != FULL_CNT);
        end
        push_s     = s_axis.tvalid & ready_s;
        out_free_s = ~out_valid_r | m_axis.tready;
        // A word already in the SRAM must leave before any bypass to keep ordering.
        if (mem_cnt_r != {CNT_W{1'b0}}) begin
            load_s   = out_free_s & ~i_rst;
            bypass_s = 1'b0;
        end else begin
            load_s   = 1'b0;
            bypass_s = out_free_s & push_s;
        end
        write_s = push_s & ~bypass_s;
    end

    assign s_axis.tready = ready_s;
    assign m_axis.tdata  = out_data_r;
    assign m_axis.tvalid = out_valid_r;
    assign o_mem_d       = s_axis.tdata;
    assign o_mem_wa      = wr_ptr_r;
    assign o_mem_we      = write_s;
    assign o_mem_ra      = rd_ptr_r;
    assign o_mem_re      = load_s;
    assign o_count       = mem_cnt_r + {{ADDR_WIDTH{1'b0}}, out_valid_r};

    // Pointer, occupancy and output-register state.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
            mem_cnt_r   <= {CNT_W{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (load_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({write_s, load_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CNT_W'(1);
                2'b01:   mem_cnt_r <= mem_cnt_r - CNT_W'(1);
                default: mem_cnt_r <= mem_cnt_r;
            endcase
            if (load_s) begin
                out_data_r  <= i_mem_q;
                out_valid_r <= 1'b1;
            end else if (bypass_s) begin
                out_data_r  <= s_axis.tdata;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= out_valid_r & ~m_axis.tready;
            end
        end
    end
endmodule

// File: tb/tb_ipsxe_floating_point_axis_fifo_ctrl_v1_0.sv
// Directed bench for the AXI-stream FIFO controller with a behavioural dual-port SRAM
// (registered write, combinational read).
module tb_ipsxe_floating_point_axis_fifo_ctrl_v1_0;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] mem_d;
    logic [AW-1:0] mem_wa;
    logic          mem_we;
    logic [AW-1:0] mem_ra;
    logic          mem_re;
    logic [DW-1:0] mem_q;
    logic [AW:0]   count;
    logic [DW-1:0] sram [DEPTH];
    logic          we_seen;

    int checks = 0;
    int failures = 0;

    ipsxe_floating_point_axis_fifo_ctrl_v1_0_if #(.DATA_WIDTH(DW)) s_if ();
    ipsxe_floating_point_axis_fifo_ctrl_v1_0_if #(.DATA_WIDTH(DW)) m_if ();

    ipsxe_floating_point_axis_fifo_ctrl_v1_0 #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .i_aclk   (clk),
        .i_rst    (rst),
        .s_axis   (s_if.slave),
        .m_axis   (m_if.master),
        .o_mem_d  (mem_d),
        .o_mem_wa (mem_wa),
        .o_mem_we (mem_we),
        .o_mem_ra (mem_ra),
        .o_mem_re (mem_re),
        .i_mem_q  (mem_q),
        .o_count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model and write-enable monitor.
    always @(posedge clk) begin
        if (mem_we) begin
            sram[mem_wa] <= mem_d;
            we_seen <= 1'b1;
        end
    end
    assign mem_q = mem_re ? sram[mem_ra] : 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int next_in;
    int next_out;
    int max_count;
    int cyc;
    logic do_push;
    logic do_pop;
    logic [DW-1:0] pop_data;

    initial begin
        rst = 1'b1;
        we_seen = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = 32'h0;
        m_if.tready = 1'b0;
        repeat (3) step();

        // T1 reset
        rst = 1'b0;
        #1;
        check_eq("rst_tvalid", 64'(m_if.tvalid), 64'h0);
        check_eq("rst_tdata", 64'(m_if.tdata), 64'h0);
        check_eq("rst_tready", 64'(s_if.tready), 64'h1);
        check_eq("rst_count", 64'(count), 64'h0);

        // T2 bypass
        we_seen = 1'b0;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'h3F80_0000;
        #1;
        check_eq("byp_we_comb", 64'(mem_we), 64'h0);
        step();
        s_if.tvalid = 1'b0;
        check_eq("byp_tvalid", 64'(m_if.tvalid), 64'h1);
        check_eq("byp_tdata", 64'(m_if.tdata), 64'h3F80_0000);
        check_eq("byp_count", 64'(count), 64'h1);
        step();
        check_eq("byp_drained", 64'(m_if.tvalid), 64'h0);
        check_eq("byp_we_seen", 64'(we_seen), 64'h0);

        // T3 fill with output stalled
        m_if.tready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata = 32'(i);
            #1;
            check_eq("fill_ready", 64'(s_if.tready), 64'h1);
            step();
        end
        check_eq("full_ready", 64'(s_if.tready), 64'h0);
        check_eq("full_count", 64'(count), 64'd17);
        s_if.tdata = 32'h11;
        step();
        check_eq("full_hold_count", 64'(count), 64'd17);
        check_eq("full_hold_ready", 64'(s_if.tready), 64'h0);
        check_eq("full_head", 64'(m_if.tdata), 64'h0);

        // T4 single pop from full
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        step();
        m_if.tready = 1'b0;
        check_eq("pop_tdata", 64'(m_if.tdata), 64'h1);
        check_eq("pop_count", 64'(count), 64'd16);
        check_eq("pop_ready", 64'(s_if.tready), 64'h1);

        // Drain the remaining words in order
        m_if.tready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            check_eq("drain_data", 64'(m_if.tdata), 64'(k));
            step();
        end
        check_eq("drain_tvalid", 64'(m_if.tvalid), 64'h0);
        check_eq("drain_count", 64'(count), 64'h0);

        // T5 random handshakes, 40 sequential words
        next_in = 0;
        next_out = 0;
        max_count = 0;
        cyc = 0;
        while (next_out < 40 && cyc < 4000) begin
            s_if.tvalid = (next_in < 40) && ($urandom_range(0, 3) != 0);
            s_if.tdata = 32'(next_in);
            m_if.tready = ($urandom_range(0, 2) == 0);
            #1;
            do_push = s_if.tvalid & s_if.tready;
            do_pop = m_if.tvalid & m_if.tready;
            pop_data = m_if.tdata;
            if (int'(count) > max_count) max_count = int'(count);
            step();
            cyc++;
            if (do_push) next_in++;
            if (do_pop) begin
                check_eq("order", 64'(pop_data), 64'(next_out));
                next_out++;
            end
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        check_eq("order_done", 64'(next_out), 64'd40);
        check_eq("max_count_ok", 64'(max_count <= 17), 64'h1);

        // T6 mid-stream reset
        for (int i = 0; i < 5; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata = 32'h20 + 32'(i);
            step();
        end
        s_if.tvalid = 1'b0;
        #1;
        check_eq("pre_rst_count", 64'(count), 64'd5);
        rst = 1'b1;
        s_if.tvalid = 1'b1;
        #1;
        check_eq("in_rst_ready", 64'(s_if.tready), 64'h0);
        check_eq("in_rst_we", 64'(mem_we), 64'h0);
        check_eq("in_rst_re", 64'(mem_re), 64'h0);
        step();
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        check_eq("post_rst_count", 64'(count), 64'h0);
        check_eq("post_rst_tvalid", 64'(m_if.tvalid), 64'h0);
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'hA;
        step();
        check_eq("after_rst_a", 64'(m_if.tdata), 64'hA);
        check_eq("after_rst_a_v", 64'(m_if.tvalid), 64'h1);
        s_if.tdata = 32'hB;
        step();
        s_if.tvalid = 1'b0;
        check_eq("after_rst_b", 64'(m_if.tdata), 64'hB);
        check_eq("after_rst_b_v", 64'(m_if.tvalid), 64'h1);
        step();
        check_eq("final_tvalid", 64'(m_if.tvalid), 64'h0);
        check_eq("final_count", 64'(count), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
